// File: rtl/phy_tx_paralelo_serie_pkg.sv
// Shared definitions for the PHY transmit serializer: comma symbol, FSM
// state encoding and a small comma-detect helper. The receive side uses the
// same comma value.
package phy_tx_paralelo_serie_pkg;

    // Idle / sync symbol (K28.5-style comma), also what the rx locks on.
    localparam logic [7:0] COMMA = 8'hBC;

    // Default number of comma bytes in the sync preamble.
    localparam int DEFAULT_SYNC_BYTES = 4;

    // Transmitter FSM: sending the sync preamble, or passing user data.
    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } tx_state_e;

    // True when a byte equals the comma symbol.
    function automatic logic is_comma(input logic [7:0] b);
        return (b == COMMA);
    endfunction

endpackage

// File: rtl/phy_tx_paralelo_serie_byte_timer.sv
// Bit timer for the serializer: a free-running 3-bit down-counter that marks
// the last bit of every byte. Reset loads 7 so the first byte after reset
// lasts a full 8 bit clocks.
module phy_tx_paralelo_serie_byte_timer
    import phy_tx_paralelo_serie_pkg::*;
(
    input  logic clk_8f,
    input  logic reset,
    output logic boundary_out
);

    logic [2:0] bit_cnt_q;
    logic [2:0] bit_cnt_d;

    // Count down every bit clock; 0 wraps naturally back to 7.
    always_comb begin
        bit_cnt_d = bit_cnt_q - 3'd1;
    end

    // Bit counter register.
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            bit_cnt_q <= 3'd7;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // The boundary is the cycle in which the LSB of the current byte is on the line.
    assign boundary_out = (bit_cnt_q == 3'd0);

endmodule

// File: rtl/phy_tx_paralelo_serie.sv
// PHY transmit serializer: 8-bit parallel bytes to a 1-bit line, MSB first,
// one bit per clk_8f, no gaps. After reset (or a resync request) it sends
// SYNC_BYTES commas before accepting user data; idle boundaries send commas.
// Optional feature macro: PHY_TX_BYTE_COUNT_EN adds byte_count_out, a 16-bit
// wrapping count of accepted valid bytes (not cleared by resync).
module phy_tx_paralelo_serie
    import phy_tx_paralelo_serie_pkg::*;
#(
    parameter int SYNC_BYTES = DEFAULT_SYNC_BYTES
) (
    input  logic        clk_8f,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic        resync_in,
    output logic        serial_out,
    output logic        sync_done_out,
`ifdef PHY_TX_BYTE_COUNT_EN
    output logic [15:0] byte_count_out,
`endif
    output logic        comma_err_out
);

    localparam int CNT_W = (SYNC_BYTES > 1) ? $clog2(SYNC_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(SYNC_BYTES - 1);

    tx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   sync_cnt_q, sync_cnt_d;
    logic               resync_pend_q, resync_pend_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               comma_err_q, comma_err_d;
    logic               boundary;
    logic               decision;
    logic               accept;

    phy_tx_paralelo_serie_byte_timer u_byte_timer (
        .clk_8f       (clk_8f),
        .reset        (reset),
        .boundary_out (boundary)
    );

    // Next-state, shift register load and handshake.
    // A "decision" boundary is either an ACTIVE boundary or the boundary that
    // ends the preamble: the byte loaded there is the first non-preamble byte,
    // so the preamble is exactly SYNC_BYTES commas (the reset value counts as
    // the first). A pending resync is honoured only on decision boundaries.
    always_comb begin
        state_d       = state_q;
        sync_cnt_d    = sync_cnt_q;
        resync_pend_d = resync_pend_q | resync_in;
        shreg_d       = {shreg_q[6:0], 1'b0};
        comma_err_d   = 1'b0;
        decision      = 1'b0;
        accept        = 1'b0;

        if (boundary) begin
            shreg_d  = COMMA;
            decision = (state_q == ST_ACTIVE) || (sync_cnt_q == LAST_SYNC);
            if (!decision) begin
                sync_cnt_d = sync_cnt_q + CNT_W'(1);
            end else if (resync_pend_q) begin
                state_d       = ST_SYNC;
                sync_cnt_d    = '0;
                resync_pend_d = 1'b0;
            end else begin
                accept  = 1'b1;
                state_d = ST_ACTIVE;
                if (valid_in) begin
                    shreg_d     = data_in;
                    comma_err_d = is_comma(data_in);
                end
            end
        end
    end

    // Serializer state registers.
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_SYNC;
            sync_cnt_q    <= '0;
            resync_pend_q <= 1'b0;
            shreg_q       <= COMMA;
            comma_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_cnt_q    <= sync_cnt_d;
            resync_pend_q <= resync_pend_d;
            shreg_q       <= shreg_d;
            comma_err_q   <= comma_err_d;
        end
    end

`ifdef PHY_TX_BYTE_COUNT_EN
    logic [15:0] byte_cnt_q, byte_cnt_d;

    // Count accepted valid bytes; wraps at 16 bits.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (accept && valid_in) begin
            byte_cnt_d = byte_cnt_q + 16'd1;
        end
    end

    // Byte counter register; only reset clears it, resync does not.
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            byte_cnt_q <= 16'd0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign byte_count_out = byte_cnt_q;
`endif

    assign serial_out    = shreg_q[7];
    assign ready_out     = accept;
    assign sync_done_out = (state_q == ST_ACTIVE);
    assign comma_err_out = comma_err_q;

endmodule
